// File: rtl/remote_bus_arbiter.sv
// Round-robin arbiter with bounded burst hold, folding NUM_CORES remote-memory buses onto one port.
// Optional per-core stall counters are built when REMOTE_ARB_STATS_EN is defined.
module remote_bus_arbiter #(
  parameter int NUM_CORES   = 4,
  parameter int BURST_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [16*NUM_CORES-1:0] core_addr,
  input  logic [NUM_CORES-1:0]    core_wren,
  input  logic [NUM_CORES-1:0]    core_rden,
  input  logic [16*NUM_CORES-1:0] core_write_val,
  output logic [NUM_CORES-1:0]    core_ready,
  output logic [16*NUM_CORES-1:0] core_read_val,
  output logic [15:0]             gmem_addr,
  output logic                    gmem_wren,
  output logic                    gmem_rden,
  output logic [15:0]             gmem_write_val,
  input  logic [15:0]             gmem_read_val,
  output logic [16*NUM_CORES-1:0] stall_count
);
  localparam int IW = $clog2(NUM_CORES);

  logic [NUM_CORES-1:0][15:0] addr_a, wdata_a, rval_a;
  logic [NUM_CORES-1:0]       req, others;
  logic [IW-1:0]              prio_ptr, owner, rd_owner, gnt_idx;
  logic [3:0]                 burst_cnt;
  logic                       rd_pending, gnt_vld;
  int                         idx;

  assign addr_a  = core_addr;
  assign wdata_a = core_write_val;
  assign req     = core_wren | core_rden;

  // Owner keeps the bus until its burst budget is spent, unless nobody else wants it.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    others  = req;
    others[owner] = 1'b0;
    if (!reset) begin
      if (req[owner] && (int'(burst_cnt) < BURST_LIMIT || !(|others))) begin
        gnt_vld = 1'b1;
        gnt_idx = owner;
      end else begin
        for (int k = 0; k < NUM_CORES; k++) begin
          idx = int'(prio_ptr) + k;
          if (idx >= NUM_CORES) idx = idx - NUM_CORES;
          if (!gnt_vld && req[idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = IW'(idx);
          end
        end
      end
    end
  end

  always_comb begin
    core_ready = '0;
    if (gnt_vld) core_ready[gnt_idx] = 1'b1;
  end

  // Write wins over read when a core raises both.
  assign gmem_addr      = gnt_vld ? addr_a[gnt_idx]  : 16'h0;
  assign gmem_write_val = gnt_vld ? wdata_a[gnt_idx] : 16'h0;
  assign gmem_wren      = gnt_vld & core_wren[gnt_idx];
  assign gmem_rden      = gnt_vld & core_rden[gnt_idx] & ~core_wren[gnt_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_ptr   <= '0;
      owner      <= '0;
      burst_cnt  <= '0;
      rd_pending <= 1'b0;
      rd_owner   <= '0;
    end else if (gnt_vld) begin
      owner      <= gnt_idx;
      burst_cnt  <= (gnt_idx == owner) ? ((burst_cnt == 4'hF) ? 4'hF : burst_cnt + 4'd1) : 4'd1;
      prio_ptr   <= (gnt_idx == IW'(NUM_CORES - 1)) ? '0 : gnt_idx + IW'(1);
      rd_pending <= gmem_rden;
      if (gmem_rden) rd_owner <= gnt_idx;
    end else begin
      burst_cnt  <= '0;
      rd_pending <= 1'b0;
    end
  end

  // Gating with reset drops a read that was in flight when reset arrived.
  always_comb begin
    rval_a = '0;
    if (rd_pending && !reset) rval_a[rd_owner] = gmem_read_val;
  end
  assign core_read_val = rval_a;

`ifdef REMOTE_ARB_STATS_EN
  logic [NUM_CORES-1:0][15:0] stall_q;
  for (genvar i = 0; i < NUM_CORES; i++) begin : g_stall
    always_ff @(posedge clk) begin
      if (reset)
        stall_q[i] <= '0;
      else if (req[i] && !core_ready[i] && stall_q[i] != 16'hFFFF)
        stall_q[i] <= stall_q[i] + 16'd1;
    end
  end
  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif
endmodule

// File: tb/tb_remote_bus_arbiter.sv
// Directed vector bench for remote_bus_arbiter: two instances (burst limit 4 and 1) share stimulus.
module tb_remote_bus_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  core_wren, core_rden;
  logic [63:0] core_addr, core_write_val;
  logic [15:0] gmem_read_val;

  logic [3:0]  rdy4, rdy1;
  logic [63:0] rv4, rv1, sc4, sc1;
  logic [15:0] ga4, ga1, gwv4, gwv1;
  logic        gw4, gw1, gr4, gr1;

  always #5 clk = ~clk;

  remote_bus_arbiter #(.NUM_CORES(4), .BURST_LIMIT(4)) u_dut4 (
    .clk(clk), .reset(reset), .core_addr(core_addr), .core_wren(core_wren),
    .core_rden(core_rden), .core_write_val(core_write_val), .core_ready(rdy4),
    .core_read_val(rv4), .gmem_addr(ga4), .gmem_wren(gw4), .gmem_rden(gr4),
    .gmem_write_val(gwv4), .gmem_read_val(gmem_read_val), .stall_count(sc4));

  remote_bus_arbiter #(.NUM_CORES(4), .BURST_LIMIT(1)) u_dut1 (
    .clk(clk), .reset(reset), .core_addr(core_addr), .core_wren(core_wren),
    .core_rden(core_rden), .core_write_val(core_write_val), .core_ready(rdy1),
    .core_read_val(rv1), .gmem_addr(ga1), .gmem_wren(gw1), .gmem_rden(gr1),
    .gmem_write_val(gwv1), .gmem_read_val(gmem_read_val), .stall_count(sc1));

  typedef struct {
    logic        rst;
    logic [3:0]  wr, rd;
    logic [63:0] addr, wdata;
    logic [15:0] rdata;
    bit          sel;
    logic [3:0]  rdy;
    logic        gw, gr;
    logic [15:0] ga, gwv;
    logic [63:0] rv;
  } vec_t;

  vec_t vecs[$];
  int   errs = 0;
  int   checks = 0;

  function automatic logic [63:0] pk(input logic [15:0] a3, a2, a1, a0);
    return {a3, a2, a1, a0};
  endfunction

  function automatic vec_t V(input logic rst, input logic [3:0] wr, rd,
                             input logic [63:0] addr, wdata, input logic [15:0] rdata,
                             input bit sel, input logic [3:0] rdy, input logic gw, gr,
                             input logic [15:0] ga, gwv, input logic [63:0] rv);
    vec_t v;
    v.rst = rst; v.wr = wr; v.rd = rd; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.sel = sel; v.rdy = rdy; v.gw = gw; v.gr = gr; v.ga = ga; v.gwv = gwv; v.rv = rv;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  initial begin
    logic [63:0] exp_sc1, exp_sc4;
    reset = 1'b1; core_wren = '0; core_rden = '0; core_addr = '0;
    core_write_val = '0; gmem_read_val = '0;

    // rst wr rd addr wdata rdata sel | rdy gw gr gaddr gwval rval
    vecs.push_back(V(1, 4'b0000, 4'b0000, 64'h0, 64'h0, 16'h0, 0, 4'b0000, 0, 0, 16'h0, 16'h0, 64'h0));
    vecs.push_back(V(1, 4'b0000, 4'b0001, pk(0, 0, 0, 16'h1111), 64'h0, 16'h0, 0, 4'b0000, 0, 0, 16'h0, 16'h0, 64'h0));
    vecs.push_back(V(0, 4'b0000, 4'b0000, 64'h0, 64'h0, 16'h0, 0, 4'b0000, 0, 0, 16'h0, 16'h0, 64'h0));
    vecs.push_back(V(0, 4'b0000, 4'b0100, pk(0, 16'h4010, 0, 0), 64'h0, 16'h0, 0, 4'b0100, 0, 1, 16'h4010, 16'h0, 64'h0));
    vecs.push_back(V(0, 4'b0000, 4'b0000, 64'h0, pk(0, 0, 16'hFFFF, 0), 16'hBEEF, 0, 4'b0000, 0, 0, 16'h0, 16'h0, pk(0, 16'hBEEF, 0, 0)));
    vecs.push_back(V(0, 4'b0000, 4'b0000, pk(0, 0, 0, 16'h9999), 64'h0, 16'h1357, 0, 4'b0000, 0, 0, 16'h0, 16'h0, 64'h0));
    vecs.push_back(V(0, 4'b0000, 4'b0001, pk(0, 0, 0, 16'h0020), 64'h0, 16'h0, 0, 4'b0001, 0, 1, 16'h0020, 16'h0, 64'h0));
    vecs.push_back(V(0, 4'b0010, 4'b0000, pk(0, 0, 16'h8000, 0), pk(0, 0, 16'h1234, 0), 16'hCAFE, 0, 4'b0010, 1, 0, 16'h8000, 16'h1234, pk(0, 0, 0, 16'hCAFE)));
    vecs.push_back(V(0, 4'b0000, 4'b0000, 64'h0, 64'h0, 16'h5555, 0, 4'b0000, 0, 0, 16'h0, 16'h0, 64'h0));
    vecs.push_back(V(0, 4'b1000, 4'b1000, pk(16'h0033, 0, 0, 0), pk(16'h00AA, 0, 0, 0), 16'h0, 0, 4'b1000, 1, 0, 16'h0033, 16'h00AA, 64'h0));
    vecs.push_back(V(0, 4'b0000, 4'b0000, 64'h0, 64'h0, 16'h7777, 0, 4'b0000, 0, 0, 16'h0, 16'h0, 64'h0));
    // burst hold: core 1 streams, core 3 waits
    vecs.push_back(V(1, 4'b0000, 4'b0000, 64'h0, 64'h0, 16'h0, 0, 4'b0000, 0, 0, 16'h0, 16'h0, 64'h0));
    vecs.push_back(V(0, 4'b0000, 4'b1010, pk(16'h0303, 0, 16'h0101, 0), 64'h0, 16'h0, 0, 4'b0010, 0, 1, 16'h0101, 16'h0, 64'h0));
    vecs.push_back(V(0, 4'b0000, 4'b1010, pk(16'h0303, 0, 16'h0101, 0), 64'h0, 16'h0A01, 0, 4'b0010, 0, 1, 16'h0101, 16'h0, pk(0, 0, 16'h0A01, 0)));
    vecs.push_back(V(0, 4'b0000, 4'b1010, pk(16'h0303, 0, 16'h0101, 0), 64'h0, 16'h0A02, 0, 4'b0010, 0, 1, 16'h0101, 16'h0, pk(0, 0, 16'h0A02, 0)));
    vecs.push_back(V(0, 4'b0000, 4'b1010, pk(16'h0303, 0, 16'h0101, 0), 64'h0, 16'h0A03, 0, 4'b0010, 0, 1, 16'h0101, 16'h0, pk(0, 0, 16'h0A03, 0)));
    vecs.push_back(V(0, 4'b0000, 4'b1010, pk(16'h0303, 0, 16'h0101, 0), 64'h0, 16'h0A04, 0, 4'b1000, 0, 1, 16'h0303, 16'h0, pk(0, 0, 16'h0A04, 0)));
    vecs.push_back(V(0, 4'b0000, 4'b0011, pk(0, 0, 16'h0101, 16'h0A0A), 64'h0, 16'h0A05, 0, 4'b0001, 0, 1, 16'h0A0A, 16'h0, pk(16'h0A05, 0, 0, 0)));
    vecs.push_back(V(0, 4'b0000, 4'b0010, pk(0, 0, 16'h0101, 0), 64'h0, 16'h0A06, 0, 4'b0010, 0, 1, 16'h0101, 16'h0, pk(0, 0, 0, 16'h0A06)));
    // reset with a read in flight, then core 0 must win
    vecs.push_back(V(1, 4'b0000, 4'b0110, pk(0, 16'h0202, 16'h0101, 0), 64'h0, 16'h0A07, 0, 4'b0000, 0, 0, 16'h0, 16'h0, 64'h0));
    vecs.push_back(V(0, 4'b0000, 4'b0111, pk(0, 16'h0202, 16'h0101, 16'h0B0B), 64'h0, 16'h0A08, 0, 4'b0001, 0, 1, 16'h0B0B, 16'h0, 64'h0));
    // round robin on the burst-limit-1 instance
    vecs.push_back(V(1, 4'b0000, 4'b0000, 64'h0, 64'h0, 16'h0, 1, 4'b0000, 0, 0, 16'h0, 16'h0, 64'h0));
    vecs.push_back(V(0, 4'b0000, 4'b1111, pk(16'h0033, 16'h0022, 16'h0011, 16'h00FF), 64'h0, 16'h0, 1, 4'b0001, 0, 1, 16'h00FF, 16'h0, 64'h0));
    vecs.push_back(V(0, 4'b0000, 4'b1111, pk(16'h0033, 16'h0022, 16'h0011, 16'h00FF), 64'h0, 16'h0B01, 1, 4'b0010, 0, 1, 16'h0011, 16'h0, pk(0, 0, 0, 16'h0B01)));
    vecs.push_back(V(0, 4'b0000, 4'b1111, pk(16'h0033, 16'h0022, 16'h0011, 16'h00FF), 64'h0, 16'h0B02, 1, 4'b0100, 0, 1, 16'h0022, 16'h0, pk(0, 0, 16'h0B02, 0)));
    vecs.push_back(V(0, 4'b0000, 4'b1111, pk(16'h0033, 16'h0022, 16'h0011, 16'h00FF), 64'h0, 16'h0B03, 1, 4'b1000, 0, 1, 16'h0033, 16'h0, pk(0, 16'h0B03, 0, 0)));

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst; core_wren = vecs[i].wr; core_rden = vecs[i].rd;
      core_addr = vecs[i].addr; core_write_val = vecs[i].wdata; gmem_read_val = vecs[i].rdata;
      #2;
      chk($sformatf("v%0d ready", i),     vecs[i].sel ? 64'(rdy1) : 64'(rdy4), 64'(vecs[i].rdy));
      chk($sformatf("v%0d gmem_wren", i), vecs[i].sel ? 64'(gw1)  : 64'(gw4),  64'(vecs[i].gw));
      chk($sformatf("v%0d gmem_rden", i), vecs[i].sel ? 64'(gr1)  : 64'(gr4),  64'(vecs[i].gr));
      chk($sformatf("v%0d gmem_addr", i), vecs[i].sel ? 64'(ga1)  : 64'(ga4),  64'(vecs[i].ga));
      chk($sformatf("v%0d gmem_wval", i), vecs[i].sel ? 64'(gwv1) : 64'(gwv4), 64'(vecs[i].gwv));
      chk($sformatf("v%0d read_val", i),  vecs[i].sel ? rv1 : rv4, vecs[i].rv);
    end

    // Stall counters after four contended cycles: rotation vs. burst hold.
`ifdef REMOTE_ARB_STATS_EN
    exp_sc1 = pk(16'd3, 16'd3, 16'd3, 16'd3);
    exp_sc4 = pk(16'd4, 16'd4, 16'd4, 16'd0);
`else
    exp_sc1 = 64'h0;
    exp_sc4 = 64'h0;
`endif
    @(negedge clk);
    core_rden = '0; core_addr = '0; gmem_read_val = 16'h0B04;
    #2;
    chk("rr last read_val", rv1, pk(16'h0B04, 0, 0, 0));
    chk("rr idle ready", 64'(rdy1), 64'h0);
    chk("stall lim1", sc1, exp_sc1);
    chk("stall lim4", sc4, exp_sc4);
    @(negedge clk);
    #2;
    chk("stall lim1 idle hold", sc1, exp_sc1);
    chk("stall lim4 idle hold", sc4, exp_sc4);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #2;
    chk("stall lim1 after reset", sc1, 64'h0);
    chk("stall lim4 after reset", sc4, 64'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
